// File: rtl/rll_key_loader.sv
// rtl/rll_key_loader.sv - key loader that assembles, frame-checks and atomically applies an RLL key
module rll_key_loader #(
  parameter int KEY_WIDTH   = 32,
  parameter int CHUNK_WIDTH = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   cfg_start,
  input  logic                   cfg_valid,
  output logic                   cfg_ready,
  input  logic [CHUNK_WIDTH-1:0] cfg_data,
  input  logic                   cfg_last,
  input  logic                   key_zero,
  output logic [KEY_WIDTH-1:0]   key_out,
  output logic                   key_valid,
  output logic                   load_err,
  output logic                   busy
);

  localparam int NBEATS = KEY_WIDTH / CHUNK_WIDTH;
  localparam int CNT_W  = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NBEATS - 1);

  // Reject key/chunk geometries that cannot be framed into whole beats
  generate
    if ((KEY_WIDTH % CHUNK_WIDTH) != 0 || CHUNK_WIDTH > KEY_WIDTH) begin : g_bad_params
      $error("rll_key_loader: KEY_WIDTH must be a non-zero multiple of CHUNK_WIDTH");
    end
  endgenerate

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_COMMIT,
    S_ERROR
  } state_t;

  state_t state, state_nxt;

  logic [KEY_WIDTH-1:0]             shadow;
  logic [CNT_W-1:0]                 cnt;
  logic [KEY_WIDTH+CHUNK_WIDTH-1:0] shift_full;
  logic                             accept;
  logic                             at_last;

  // A beat presented alongside a restart or zeroize is dropped, so both take precedence here
  assign accept     = (state == S_LOAD) && cfg_valid && !cfg_start && !key_zero;
  assign at_last    = (cnt == LAST_CNT);
  assign shift_full = {shadow, cfg_data};

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  // Next-state decode plus the two state-decoded outputs
  always_comb begin
    state_nxt = state;
    cfg_ready = 1'b0;
    busy      = 1'b0;
    case (state)
      S_IDLE: begin
        if (cfg_start) state_nxt = S_LOAD;
      end
      S_LOAD: begin
        cfg_ready = 1'b1;
        busy      = 1'b1;
        if (cfg_start) begin
          state_nxt = S_LOAD;
        end else if (accept) begin
          if (cfg_last && at_last)      state_nxt = S_COMMIT;
          else if (cfg_last || at_last) state_nxt = S_ERROR;
        end
      end
      S_COMMIT: begin
        busy      = 1'b1;
        state_nxt = S_IDLE;
      end
      S_ERROR: begin
        if (cfg_start) state_nxt = S_LOAD;
      end
      default: state_nxt = S_IDLE;
    endcase
    if (key_zero) state_nxt = S_IDLE;
  end

  // Shadow assembly, beat counter, atomic commit and sticky framing error
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shadow    <= '0;
      cnt       <= '0;
      key_out   <= '0;
      key_valid <= 1'b0;
      load_err  <= 1'b0;
    end else if (key_zero) begin
      shadow    <= '0;
      cnt       <= '0;
      key_out   <= '0;
      key_valid <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_ERROR: begin
          if (cfg_start) begin
            cnt      <= '0;
            shadow   <= '0;
            load_err <= 1'b0;
          end else if (state == S_ERROR) begin
            shadow <= '0;
          end
        end
        S_LOAD: begin
          if (cfg_start) begin
            cnt      <= '0;
            shadow   <= '0;
            load_err <= 1'b0;
          end else if (accept) begin
            shadow <= shift_full[KEY_WIDTH-1:0];
            cnt    <= cnt + CNT_W'(1);
            // Early last or missing last: flag on the same edge that leaves LOAD
            if (cfg_last ^ at_last) load_err <= 1'b1;
          end
        end
        S_COMMIT: begin
          key_out   <= shadow;
          key_valid <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
